// File: rtl/hazard_ctrl_mc_if.sv
// Signal bundle between the five-stage datapath and the hazard controller.
// Valid/ready: none; every field is a level signal sampled each cycle, no handshake is implied.
interface hazard_ctrl_mc_if #(
    parameter int AW = 5,
    parameter int CW = 16
);
    logic [AW-1:0] Rs1_D;
    logic [AW-1:0] Rs2_D;
    logic [AW-1:0] Rs1_E;
    logic [AW-1:0] Rs2_E;
    logic [AW-1:0] RD_E;
    logic          RegWriteE;
    logic          ResultSrcE;
    logic          MulDivE;
    logic          PCSrcE;
    logic [AW-1:0] RD_M;
    logic          RegWriteM;
    logic [AW-1:0] RD_W;
    logic          RegWriteW;

    logic [1:0]    ForwardAE;
    logic [1:0]    ForwardBE;
    logic          StallF;
    logic          StallD;
    logic          StallE;
    logic          FlushD;
    logic          FlushE;
    logic          FlushM;
    logic          MulDivDone;
    logic [CW-1:0] StallCnt;
    logic          dbg_busy;
    logic [7:0]    dbg_cnt;

    modport slave (
        input  Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RegWriteE, ResultSrcE, MulDivE,
               PCSrcE, RD_M, RegWriteM, RD_W, RegWriteW,
        output ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE,
               FlushM, MulDivDone, StallCnt, dbg_busy, dbg_cnt
    );

    modport master (
        output Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RegWriteE, ResultSrcE, MulDivE,
               PCSrcE, RD_M, RegWriteM, RD_W, RegWriteW,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE,
               FlushM, MulDivDone, StallCnt, dbg_busy, dbg_cnt
    );
endinterface

// File: rtl/hazard_ctrl_mc.sv
// Pipeline hazard controller: forwarding, load-use stall, branch flush,
// multi-cycle mul/div sequencing and a saturating stall counter.
module hazard_ctrl_mc #(
    parameter int AW     = 5,
    parameter int MD_LAT = 4,
    parameter int CW     = 16
) (
    input  logic             clk,
    input  logic             rst,
    hazard_ctrl_mc_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_t;

    localparam logic [7:0] MD_LOAD = 8'(MD_LAT - 2);

    md_state_t     r_state;
    logic [7:0]    r_cnt;
    logic          r_md_hold;
    logic          r_md_done;
    logic [CW-1:0] r_stall_cnt;

    logic          w_md_stall;
    logic          w_lu;
    logic          w_br;
    logic          w_stall_f;

    function automatic logic [1:0] fwd_sel(
        input logic [AW-1:0] rs,
        input logic          wm,
        input logic [AW-1:0] rdm,
        input logic          ww,
        input logic [AW-1:0] rdw
    );
        if (wm && (rdm != '0) && (rdm == rs)) return 2'b10;
        if (ww && (rdw != '0) && (rdw == rs)) return 2'b01;
        return 2'b00;
    endfunction

    // Hold/done are registered one cycle ahead so only the IDLE entry is combinational on MulDivE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cnt     <= 8'd0;
            r_md_hold <= 1'b0;
            r_md_done <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.MulDivE) begin
                        r_state   <= BUSY;
                        r_cnt     <= MD_LOAD;
                        r_md_hold <= (MD_LOAD != 8'd0);
                        r_md_done <= (MD_LOAD == 8'd0);
                    end
                end
                BUSY: begin
                    if (r_cnt != 8'd0) begin
                        r_cnt     <= r_cnt - 8'd1;
                        r_md_hold <= (r_cnt != 8'd1);
                        r_md_done <= (r_cnt == 8'd1);
                    end else begin
                        r_state   <= IDLE;
                        r_md_hold <= 1'b0;
                        r_md_done <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        w_md_stall = rst & (((r_state == IDLE) & bus.MulDivE) | r_md_hold);
        w_br       = rst & bus.PCSrcE;
        w_lu       = rst & bus.ResultSrcE & bus.RegWriteE & (bus.RD_E != '0)
                   & ((bus.RD_E == bus.Rs1_D) | (bus.RD_E == bus.Rs2_D));
        // Execute is frozen during mul/div, so the load-use bubble has nowhere to go.
        w_stall_f  = w_md_stall | (w_lu & ~w_br);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall_f && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign bus.ForwardAE  = rst ? fwd_sel(bus.Rs1_E, bus.RegWriteM, bus.RD_M,
                                          bus.RegWriteW, bus.RD_W) : 2'b00;
    assign bus.ForwardBE  = rst ? fwd_sel(bus.Rs2_E, bus.RegWriteM, bus.RD_M,
                                          bus.RegWriteW, bus.RD_W) : 2'b00;
    assign bus.StallF     = w_stall_f;
    assign bus.StallD     = w_stall_f;
    assign bus.StallE     = w_md_stall;
    assign bus.FlushD     = w_br;
    assign bus.FlushE     = ~w_md_stall & (w_br | w_lu);
    assign bus.FlushM     = w_md_stall;
    assign bus.MulDivDone = rst & r_md_done;
    assign bus.StallCnt   = r_stall_cnt;
    assign bus.dbg_busy   = (r_state == BUSY);
    assign bus.dbg_cnt    = r_cnt;
endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Directed bench for hazard_ctrl_mc: main instance (CW=16) plus a CW=2 instance
// sharing the same stimulus for the saturation case.
module tb_hazard_ctrl_mc;
  logic clk;
  logic rst;

  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       reg_write_e, result_src_e, mul_div_e, pc_src_e, reg_write_m, reg_write_w;

  int checks;
  int failures;

  hazard_ctrl_mc_if #(.AW(5), .CW(16)) bus ();
  hazard_ctrl_mc_if #(.AW(5), .CW(2))  bus2 ();

  hazard_ctrl_mc #(.AW(5), .MD_LAT(4), .CW(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  hazard_ctrl_mc #(.AW(5), .MD_LAT(4), .CW(2)) dut_sat (
    .clk(clk),
    .rst(rst),
    .bus(bus2)
  );

  assign bus.Rs1_D       = rs1_d;
  assign bus.Rs2_D       = rs2_d;
  assign bus.Rs1_E       = rs1_e;
  assign bus.Rs2_E       = rs2_e;
  assign bus.RD_E        = rd_e;
  assign bus.RegWriteE   = reg_write_e;
  assign bus.ResultSrcE  = result_src_e;
  assign bus.MulDivE     = mul_div_e;
  assign bus.PCSrcE      = pc_src_e;
  assign bus.RD_M        = rd_m;
  assign bus.RegWriteM   = reg_write_m;
  assign bus.RD_W        = rd_w;
  assign bus.RegWriteW   = reg_write_w;

  assign bus2.Rs1_D      = rs1_d;
  assign bus2.Rs2_D      = rs2_d;
  assign bus2.Rs1_E      = rs1_e;
  assign bus2.Rs2_E      = rs2_e;
  assign bus2.RD_E       = rd_e;
  assign bus2.RegWriteE  = reg_write_e;
  assign bus2.ResultSrcE = result_src_e;
  assign bus2.MulDivE    = mul_div_e;
  assign bus2.PCSrcE     = pc_src_e;
  assign bus2.RD_M       = rd_m;
  assign bus2.RegWriteM  = reg_write_m;
  assign bus2.RD_W       = rd_w;
  assign bus2.RegWriteW  = reg_write_w;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checking
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // A branch must never resolve while a mul/div holds Execute.
  always @(negedge clk) begin
    if (rst && bus.dbg_busy) check_val("pcsrc_in_busy", {31'd0, pc_src_e}, 32'd0);
  end

  // drivers
  task automatic clear_inputs();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    reg_write_e = 0; result_src_e = 0; mul_div_e = 0; pc_src_e = 0;
    reg_write_m = 0; reg_write_w = 0;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_fwd_a"}, {30'd0, bus.ForwardAE}, 32'd0);
    check_val({tag, "_fwd_b"}, {30'd0, bus.ForwardBE}, 32'd0);
    check_val({tag, "_stalls"}, {29'd0, bus.StallF, bus.StallD, bus.StallE}, 32'd0);
    check_val({tag, "_flushes"}, {29'd0, bus.FlushD, bus.FlushE, bus.FlushM}, 32'd0);
    check_val({tag, "_done"}, {31'd0, bus.MulDivDone}, 32'd0);
    check_val({tag, "_cnt"}, {16'd0, bus.StallCnt}, 32'd0);
    check_val({tag, "_busy"}, {31'd0, bus.dbg_busy}, 32'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    advance();
    rst = 1'b1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    clear_inputs();
    rst = 1'b0;

    // Reset with inputs that would otherwise forward, stall and start a mul/div.
    reg_write_m = 1; rd_m = 5; rs1_e = 5; mul_div_e = 1;
    result_src_e = 1; reg_write_e = 1; rd_e = 7; rs2_d = 7;
    settle();
    check_all_zero("reset");
    advance();
    clear_inputs();
    rst = 1'b1;

    // Forward priority: M beats W, index 0 never forwarded.
    reg_write_m = 1; rd_m = 5; reg_write_w = 1; rd_w = 5; rs1_e = 5; rs2_e = 0;
    settle();
    check_val("fwd_mw_a", {30'd0, bus.ForwardAE}, 32'd2);
    check_val("fwd_mw_b", {30'd0, bus.ForwardBE}, 32'd0);
    advance();
    rd_w = 0;
    settle();
    check_val("fwd_m_a", {30'd0, bus.ForwardAE}, 32'd2);
    check_val("fwd_m_b", {30'd0, bus.ForwardBE}, 32'd0);
    advance();
    reg_write_m = 0; rd_w = 5; rs2_e = 5;
    settle();
    check_val("fwd_w_a", {30'd0, bus.ForwardAE}, 32'd1);
    check_val("fwd_w_b", {30'd0, bus.ForwardBE}, 32'd1);
    advance();
    reg_write_m = 1; rd_m = 0; rd_w = 0; rs1_e = 0; rs2_e = 0;
    settle();
    check_val("fwd_zero_a", {30'd0, bus.ForwardAE}, 32'd0);
    check_val("fwd_none_stall", {31'd0, bus.StallF}, 32'd0);
    advance();
    clear_inputs();

    // Load-use: one bubble, counter 0 -> 1.
    result_src_e = 1; reg_write_e = 1; rd_e = 7; rs2_d = 7;
    settle();
    check_val("lu_stalls", {29'd0, bus.StallF, bus.StallD, bus.FlushE}, 32'd7);
    check_val("lu_no_stall_e", {31'd0, bus.StallE}, 32'd0);
    check_val("lu_cnt_before", {16'd0, bus.StallCnt}, 32'd0);
    advance();
    clear_inputs();
    settle();
    check_val("lu_cnt_after", {16'd0, bus.StallCnt}, 32'd1);
    check_val("lu_released", {29'd0, bus.StallF, bus.StallD, bus.FlushE}, 32'd0);
    advance();
    result_src_e = 1; reg_write_e = 1; rd_e = 0; rs1_d = 0; rs2_d = 0;
    settle();
    check_val("lu_rd0", {29'd0, bus.StallF, bus.StallD, bus.FlushE}, 32'd0);
    advance();
    clear_inputs();

    // Branch beats load-use in the same cycle.
    result_src_e = 1; reg_write_e = 1; rd_e = 9; rs1_d = 9; pc_src_e = 1;
    settle();
    check_val("br_lu_flush", {30'd0, bus.FlushD, bus.FlushE}, 32'd3);
    check_val("br_lu_stall", {30'd0, bus.StallF, bus.StallD}, 32'd0);
    advance();
    clear_inputs();
    settle();
    check_val("br_lu_cnt", {16'd0, bus.StallCnt}, 32'd1);
    advance();

    // Back-to-back mul/div with MD_LAT=4; CW=2 instance saturates along the way.
    pulse_reset();
    for (int c = 0; c < 8; c++) begin
      mul_div_e = 1;
      clear_inputs();
      mul_div_e = 1;
      if (c == 1) begin
        result_src_e = 1; reg_write_e = 1; rd_e = 4; rs1_d = 4;
      end
      if (c == 2) begin
        reg_write_m = 1; rd_m = 3; rs1_e = 3;
      end
      settle();
      check_val($sformatf("md_stall_c%0d", c),
                {28'd0, bus.StallF, bus.StallD, bus.StallE, bus.FlushM},
                (c % 4 != 3) ? 32'hF : 32'h0);
      check_val($sformatf("md_done_c%0d", c), {31'd0, bus.MulDivDone},
                (c % 4 == 3) ? 32'd1 : 32'd0);
      if (c == 1) check_val("md_lu_flush_e", {31'd0, bus.FlushE}, 32'd0);
      if (c == 2) check_val("md_fwd_live", {30'd0, bus.ForwardAE}, 32'd2);
      if (c == 3) check_val("md_cnt_c3", {16'd0, bus.StallCnt}, 32'd3);
      if (c == 3) check_val("sat_cnt_c3", {30'd0, bus2.StallCnt}, 32'd3);
      if (c == 7) check_val("md_cnt_c7", {16'd0, bus.StallCnt}, 32'd6);
      if (c == 7) check_val("sat_cnt_c7", {30'd0, bus2.StallCnt}, 32'd3);
      advance();
    end
    clear_inputs();
    settle();
    check_val("md_idle_after", {30'd0, bus.StallF, bus.dbg_busy}, 32'd0);
    advance();

    // Reset mid-BUSY: outputs clear at once, no resumption afterwards.
    mul_div_e = 1;
    settle();
    check_val("rb_c0_stall", {31'd0, bus.StallF}, 32'd1);
    advance();
    settle();
    check_val("rb_c1_busy", {31'd0, bus.dbg_busy}, 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("rb_async");
    advance();
    rst = 1'b1;
    mul_div_e = 0;
    settle();
    check_val("rb_release_idle", {30'd0, bus.StallF, bus.dbg_busy}, 32'd0);
    check_val("rb_release_done", {31'd0, bus.MulDivDone}, 32'd0);
    advance();

    // Fresh mul/div after reset runs the full length.
    mul_div_e = 1;
    for (int c = 0; c < 4; c++) begin
      settle();
      check_val($sformatf("rb_md_done_c%0d", c), {31'd0, bus.MulDivDone},
                (c == 3) ? 32'd1 : 32'd0);
      advance();
    end
    clear_inputs();
    settle();
    check_val("rb_md_cnt", {16'd0, bus.StallCnt}, 32'd3);
    advance();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
